q_update_pipe: RTL and testbench

- Pipelined, parametrised Q-learning update engine: Q_new = Q_old + alpha*(R + gamma*maxQ_next - Q_old).
- Successor to the combinational update datapath:
  - configurable word and fraction width;
  - gamma multiply folded in;
  - 4-stage registered pipeline with valid/ready backpressure;
  - optional saturation with overflow flag.
- Sits between the Q-table read port (Q_old, maxQ_next) and the Q-table write-back port.

---
 rtl/q_update_pipe.sv | 133 +++++++++++++
 tb/tb_q_update_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/q_update_pipe.sv
// q_update_pipe: 4-stage sign-magnitude Q-learning update, Q_new = Q_old + alpha*(R + gamma*maxQ' - Q_old).
// Build with Q_UPDATE_SAT_EN to saturate every reduction and report ovf; otherwise magnitudes wrap and ovf stays 0.
module q_update_pipe #(
  parameter int N = 14,
  parameter int Q = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] q_old,
  input  logic [N-1:0] reward,
  input  logic [N-1:0] max_q_next,
  input  logic [N-1:0] gamma,
  input  logic [N-1:0] alpha,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q_new,
  output logic         ovf
);
  localparam int M  = N - 1;
  localparam int EW = N + 1;
  localparam int RW = 2 * M;
`ifdef Q_UPDATE_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Reduce a wide magnitude to N bits; returns {ovf_event, sign, magnitude} with zero forced to +0.
  function automatic logic [N:0] sm_reduce(input logic sgn, input logic [RW-1:0] mag_w);
    logic         evt;
    logic [M-1:0] mag;
    logic         sgn_o;
    evt = |mag_w[RW-1:M];
    if (SAT_EN && evt) mag = {M{1'b1}};
    else               mag = mag_w[M-1:0];
    if (mag == {M{1'b0}}) sgn_o = 1'b0;
    else                  sgn_o = sgn;
    return {SAT_EN & evt, sgn_o, mag};
  endfunction

  function automatic logic [N:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [RW-1:0] prod;
    prod = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
    return sm_reduce(a[N-1] ^ b[N-1], prod >> Q);
  endfunction

  // Exact sign-magnitude add in the extended width; operands never exceed 2^(M+1) so no carry out.
  function automatic logic [EW:0] sm_add(input logic sa, input logic [EW-1:0] ma,
                                         input logic sb, input logic [EW-1:0] mb);
    logic [EW:0] r;
    if (sa == sb)      r = {sa, ma + mb};
    else if (ma >= mb) r = {sa, ma - mb};
    else               r = {sb, mb - ma};
    return r;
  endfunction

  function automatic logic [EW-1:0] mag_ext(input logic [M-1:0] m);
    return {{(EW-M){1'b0}}, m};
  endfunction

  logic          advance_s;
  logic [N:0]    g_res_s, t_res_s, p_res_s, q_res_s;
  logic [EW:0]   rg_sum_s, t_ext_s, q_ext_s;
  logic          v1_r, v2_r, v3_r, out_valid_r;
  logic [N-1:0]  g1_r, q_old1_r, reward1_r, alpha1_r;
  logic [N-1:0]  t2_r, q_old2_r, alpha2_r;
  logic [N-1:0]  p3_r, q_old3_r;
  logic [N-1:0]  q_new_r;
  logic          ovf1_r, ovf2_r, ovf3_r, ovf_r;

  assign advance_s = ~out_valid_r | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = out_valid_r;
  assign q_new     = q_new_r;
  assign ovf       = ovf_r;

  // Per-stage arithmetic feeding the next pipeline register
  always_comb begin
    g_res_s  = sm_mul(gamma, max_q_next);
    rg_sum_s = sm_add(reward1_r[N-1], mag_ext(reward1_r[M-1:0]), g1_r[N-1], mag_ext(g1_r[M-1:0]));
    t_ext_s  = sm_add(rg_sum_s[EW], rg_sum_s[EW-1:0], ~q_old1_r[N-1], mag_ext(q_old1_r[M-1:0]));
    t_res_s  = sm_reduce(t_ext_s[EW], {{(RW-EW){1'b0}}, t_ext_s[EW-1:0]});
    p_res_s  = sm_mul(alpha2_r, t2_r);
    q_ext_s  = sm_add(q_old3_r[N-1], mag_ext(q_old3_r[M-1:0]), p3_r[N-1], mag_ext(p3_r[M-1:0]));
    q_res_s  = sm_reduce(q_ext_s[EW], {{(RW-EW){1'b0}}, q_ext_s[EW-1:0]});
  end

  // Pipeline registers: cleared on reset, all stages shift together on advance, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r        <= 1'b0;
      g1_r        <= {N{1'b0}};
      ovf1_r      <= 1'b0;
      q_old1_r    <= {N{1'b0}};
      reward1_r   <= {N{1'b0}};
      alpha1_r    <= {N{1'b0}};
      v2_r        <= 1'b0;
      t2_r        <= {N{1'b0}};
      ovf2_r      <= 1'b0;
      q_old2_r    <= {N{1'b0}};
      alpha2_r    <= {N{1'b0}};
      v3_r        <= 1'b0;
      p3_r        <= {N{1'b0}};
      ovf3_r      <= 1'b0;
      q_old3_r    <= {N{1'b0}};
      out_valid_r <= 1'b0;
      q_new_r     <= {N{1'b0}};
      ovf_r       <= 1'b0;
    end else if (advance_s) begin
      v1_r        <= in_valid;
      g1_r        <= g_res_s[N-1:0];
      ovf1_r      <= g_res_s[N];
      q_old1_r    <= q_old;
      reward1_r   <= reward;
      alpha1_r    <= alpha;
      v2_r        <= v1_r;
      t2_r        <= t_res_s[N-1:0];
      ovf2_r      <= ovf1_r | t_res_s[N];
      q_old2_r    <= q_old1_r;
      alpha2_r    <= alpha1_r;
      v3_r        <= v2_r;
      p3_r        <= p_res_s[N-1:0];
      ovf3_r      <= ovf2_r | p_res_s[N];
      q_old3_r    <= q_old2_r;
      out_valid_r <= v3_r;
      q_new_r     <= q_res_s[N-1:0];
      ovf_r       <= ovf3_r | q_res_s[N];
    end
  end

endmodule

// File: tb/tb_q_update_pipe.sv
// Directed, table-driven bench for q_update_pipe (N=14, Q=10) in both the wrap and
// Q_UPDATE_SAT_EN builds, plus backpressure and mid-flight reset sequences.
module tb_q_update_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] q_old, reward, max_q_next, gamma, alpha;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] q_new;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] q_old;
    logic [13:0] reward;
    logic [13:0] max_q_next;
    logic [13:0] gamma;
    logic [13:0] alpha;
    logic [13:0] exp_q;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [9];

  q_update_pipe #(.N(14), .Q(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q_old(q_old), .reward(reward), .max_q_next(max_q_next), .gamma(gamma), .alpha(alpha),
    .out_valid(out_valid), .out_ready(out_ready), .q_new(q_new), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    q_old      = v.q_old;
    reward     = v.reward;
    max_q_next = v.max_q_next;
    gamma      = v.gamma;
    alpha      = v.alpha;
  endtask

  function automatic vec_t mk_item(input int k);
    vec_t v;
    v.q_old      = 14'd0;
    v.reward     = 14'(k * 100);
    v.max_q_next = 14'd0;
    v.gamma      = 14'd0;
    v.alpha      = 14'd1024;
    v.exp_q      = 14'(k * 100);
    v.exp_ovf    = 1'b0;
    return v;
  endfunction

  // One isolated item: not valid at cycle 3, valid with the right value at cycle 4.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    out_ready = 1'b1;
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({name, "_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_q"}, {18'd0, q_new}, {18'd0, v.exp_q});
    check({name, "_ovf"}, {31'd0, ovf}, {31'd0, v.exp_ovf});
  endtask

  initial begin
    int sent, got, stall_bad, extra, stale;
    logic acc;

    vecs[0] = '{14'd0,    14'd1024,   14'd0,      14'd922,  14'd512,  14'd512,    1'b0};
    vecs[1] = '{14'd512,  14'd0,      14'd1024,   14'd922,  14'd512,  14'd717,    1'b0};
    vecs[2] = '{14'd1024, 14'h2400,   14'd0,      14'd922,  14'd512,  14'h0000,   1'b0};
    vecs[4] = '{14'd0,    14'd0,      14'h2800,   14'd512,  14'd1024, 14'h2400,   1'b0};
    vecs[5] = '{14'h2000, 14'h2000,   14'd0,      14'd0,    14'd1024, 14'h0000,   1'b0};
    vecs[6] = '{14'd0,    14'h2003,   14'd0,      14'd0,    14'd512,  14'h2001,   1'b0};
`ifdef Q_UPDATE_SAT_EN
    vecs[3] = '{14'd4096, 14'd8191,   14'd8191,   14'd1024, 14'd1024, 14'd8191,   1'b1};
    vecs[7] = '{14'd0,    14'd0,      14'd4096,   14'd4096, 14'd1024, 14'd8191,   1'b1};
    vecs[8] = '{14'd4000, 14'h3F40,   14'd0,      14'd0,    14'd1024, 14'h305F,   1'b1};
`else
    vecs[3] = '{14'd4096, 14'd8191,   14'd8191,   14'd1024, 14'd1024, 14'd8190,   1'b0};
    vecs[7] = '{14'd0,    14'd0,      14'd4096,   14'd4096, 14'd1024, 14'h0000,   1'b0};
    vecs[8] = '{14'd4000, 14'h3F40,   14'd0,      14'd0,    14'd1024, 14'h00C0,   1'b0};
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(mk_item(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q_new", {18'd0, q_new}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: fill with out_ready low, then drain.
    @(negedge clk);
    out_ready = 1'b0;
    sent = 0; got = 0; stall_bad = 0; extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid && q_new !== 14'd100) stall_bad++;
      if (sent < 6) begin
        drive(mk_item(sent + 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    check("bp_accepted", sent, 32'd4);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_held_q", {18'd0, q_new}, 32'd100);
    check("bp_stable", stall_bad, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (got < 6) check($sformatf("bp_out%0d", got), {18'd0, q_new}, (got + 1) * 100);
        else extra++;
        got++;
      end
      if (sent < 6) begin
        drive(mk_item(sent + 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    check("bp_sent", sent, 32'd6);
    check("bp_got", got, 32'd6);
    check("bp_extra", extra, 32'd0);

    // Reset with items in flight and one at the output.
    for (int c = 0; c < 4; c++) begin
      drive(mk_item(c + 1));
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rf_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rf_valid_drop", {31'd0, out_valid}, 32'd0);
    check("rf_q_clear", {18'd0, q_new}, 32'd0);
    check("rf_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rf_no_stale", stale, 32'd0);
    run_vec(vecs[1], "rf_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
